// File: rtl/phase1_pkg.sv
// Shared types and constants for the phase-1 sequencer.
package phase1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SHOW_OK,
        ST_SHOW_NG,
        ST_DONE,
        ST_LOST
    } state_e;

    localparam logic [31:0] OK_PATTERN = 32'hAAAA_AAAA;
    localparam logic [31:0] NG_PATTERN = 32'hEEEE_EEEE;

    localparam logic [3:0] KEY_SUBMIT = 4'd0;
    localparam logic [3:0] KEY_STAR   = 4'd10;
    localparam logic [3:0] KEY_HASH   = 4'd11;

endpackage

// File: rtl/phase1_stage_ctrl_sec_countdown.sv
// Tick prescaler plus seconds down-counter with load/run/pause control.
module sec_countdown #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_LIMIT_S  = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        run,
    input  logic        pause,
    output logic [15:0] sec,
    output logic        expire
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   sec_q, sec_d;
    logic          count;

    always_comb begin
        tick_d = tick_q;
        sec_d  = sec_q;
        expire = 1'b0;
        count  = run & ~pause;
        if (load) begin
            tick_d = '0;
            sec_d  = 16'(TIME_LIMIT_S);
        end else if (count) begin
            if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
                tick_d = '0;
                if (sec_q != 16'd0) sec_d = sec_q - 16'd1;
                if (sec_q == 16'd1) expire = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= '0;
            sec_q  <= 16'(TIME_LIMIT_S);
        end else begin
            tick_q <= tick_d;
            sec_q  <= sec_d;
        end
    end

    assign sec = sec_q;

endmodule

// File: rtl/phase1_stage_ctrl.sv
// Phase-1 sequencer: runs puzzles in order, owns timer, lives and display mux.
module phase1_stage_ctrl
    import phase1_pkg::*;
#(
    parameter int NUM_PUZZLES   = 3,
    parameter int MAX_FAILS     = 3,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_LIMIT_S  = 180,
    parameter int HOLD_CYCLES   = 25_000_000,
    localparam int IW = (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1,
    localparam int LW = $clog2(MAX_FAILS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     key_valid,
    input  logic [3:0]               key_value,
    input  logic [NUM_PUZZLES-1:0]   puz_clear,
    input  logic [NUM_PUZZLES-1:0]   puz_fail,
    input  logic [32*NUM_PUZZLES-1:0] puz_seg,
    input  logic [8*NUM_PUZZLES-1:0] puz_led,
    output logic [NUM_PUZZLES-1:0]   puz_enable,
    output logic                     puz_key_valid,
    output logic [3:0]               puz_key_value,
    output logic [31:0]              seg_data,
    output logic [7:0]               led_out,
    output logic [15:0]              timer_data,
    output logic [LW-1:0]            lives,
    output logic [IW-1:0]            cur_idx,
    output logic                     phase_done,
    output logic                     phase_fail
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] fail_cnt_q, fail_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          load, expire, in_run, in_show;
    logic          act_clear, act_fail;
    logic [31:0]   slot_seg;
    logic [7:0]    slot_led;

    assign in_run  = (state_q == ST_RUN);
    assign in_show = (state_q == ST_SHOW_OK) || (state_q == ST_SHOW_NG);

    sec_countdown #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .TIME_LIMIT_S (TIME_LIMIT_S)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .run   (in_run | in_show),
        .pause (in_show),
        .sec   (timer_data),
        .expire(expire)
    );

    // Only the active slot's pulses and display data matter.
    always_comb begin
        act_clear = 1'b0;
        act_fail  = 1'b0;
        slot_seg  = '0;
        slot_led  = '0;
        for (int k = 0; k < NUM_PUZZLES; k++) begin
            if (IW'(k) == idx_q) begin
                act_clear = puz_clear[k];
                act_fail  = puz_fail[k];
                slot_seg  = puz_seg[32*k +: 32];
                slot_led  = puz_led[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fail_cnt_d = fail_cnt_q;
        hold_d     = hold_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_LOST: begin
                if (start) begin
                    state_d    = ST_RUN;
                    idx_d      = '0;
                    fail_cnt_d = '0;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (act_clear) begin
                    state_d = ST_SHOW_OK;
                    hold_d  = '0;
                end else if (expire) begin
                    state_d = ST_LOST;
                end else if (act_fail) begin
                    fail_cnt_d = fail_cnt_q + LW'(1);
                    hold_d     = '0;
                    if (fail_cnt_q + LW'(1) == LW'(MAX_FAILS)) state_d = ST_LOST;
                    else                                        state_d = ST_SHOW_NG;
                end
            end
            ST_SHOW_OK, ST_SHOW_NG: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = ST_RUN;
                    if (state_q == ST_SHOW_OK) begin
                        if (idx_q == IW'(NUM_PUZZLES - 1)) state_d = ST_DONE;
                        else                               idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            fail_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fail_cnt_q <= fail_cnt_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        puz_enable = '0;
        seg_data   = '0;
        led_out    = '0;
        case (state_q)
            ST_RUN: begin
                puz_enable = NUM_PUZZLES'(1) << idx_q;
                seg_data   = slot_seg;
                led_out    = slot_led;
            end
            ST_SHOW_OK, ST_DONE: begin
                seg_data = OK_PATTERN;
                led_out  = 8'hFF;
            end
            ST_SHOW_NG, ST_LOST: seg_data = NG_PATTERN;
            default: ;
        endcase
    end

    assign puz_key_valid = key_valid & in_run;
    assign puz_key_value = key_value;
    assign lives         = LW'(MAX_FAILS) - fail_cnt_q;
    assign cur_idx       = idx_q;
    assign phase_done    = (state_q == ST_DONE);
    assign phase_fail    = (state_q == ST_LOST);

endmodule

// File: tb/tb_phase1_stage_ctrl.sv
// Directed bench for phase1_stage_ctrl with small timer/hold constants.
module tb_phase1_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [2:0]  puz_clear;
    logic [2:0]  puz_fail;
    logic [95:0] puz_seg;
    logic [23:0] puz_led;
    logic [2:0]  puz_enable;
    logic        puz_key_valid;
    logic [3:0]  puz_key_value;
    logic [31:0] seg_data;
    logic [7:0]  led_out;
    logic [15:0] timer_data;
    logic [1:0]  lives;
    logic [1:0]  cur_idx;
    logic        phase_done;
    logic        phase_fail;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phase1_stage_ctrl #(
        .NUM_PUZZLES  (3),
        .MAX_FAILS    (3),
        .TICKS_PER_SEC(4),
        .TIME_LIMIT_S (5),
        .HOLD_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_valid    (key_valid),
        .key_value    (key_value),
        .puz_clear    (puz_clear),
        .puz_fail     (puz_fail),
        .puz_seg      (puz_seg),
        .puz_led      (puz_led),
        .puz_enable   (puz_enable),
        .puz_key_valid(puz_key_valid),
        .puz_key_value(puz_key_value),
        .seg_data     (seg_data),
        .led_out      (led_out),
        .timer_data   (timer_data),
        .lives        (lives),
        .cur_idx      (cur_idx),
        .phase_done   (phase_done),
        .phase_fail   (phase_fail)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input logic [2:0] v);
        puz_clear = v;
        cyc();
        puz_clear = '0;
    endtask

    task automatic pulse_fail(input logic [2:0] v);
        puz_fail = v;
        cyc();
        puz_fail = '0;
    endtask

    task automatic show3(input string tag, input logic [31:0] pat);
        for (int i = 0; i < 3; i++) begin
            check(tag, seg_data, pat);
            cyc();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        key_valid = 1'b0;
        key_value = 4'd0;
        puz_clear = '0;
        puz_fail  = '0;
        puz_seg   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        puz_led   = {8'h12, 8'h11, 8'h10};
        cyc();
        cyc();
        rst_n = 1'b1;

        check("rst_en", 32'(puz_enable), 32'h0);
        check("rst_seg", seg_data, 32'h0);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_timer", 32'(timer_data), 32'd5);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_done", 32'(phase_done), 32'd0);
        check("rst_fail", 32'(phase_fail), 32'd0);

        key_valid = 1'b1;
        key_value = 4'd11;
        #1;
        check("idle_kv", 32'(puz_key_valid), 32'd0);
        check("key_pass", 32'(puz_key_value), 32'd11);
        key_valid = 1'b0;

        // Clear all three puzzles in order.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("run0_en", 32'(puz_enable), 32'b001);
        check("run0_seg", seg_data, 32'h1111_1111);
        check("run0_led", 32'(led_out), 32'h10);
        key_valid = 1'b1;
        #1;
        check("run_kv", 32'(puz_key_valid), 32'd1);
        key_valid = 1'b0;
        pulse_clear(3'b001);
        check("ok_en", 32'(puz_enable), 32'b000);
        check("ok_led", 32'(led_out), 32'hFF);
        show3("ok0_seg", 32'hAAAA_AAAA);
        check("run1_en", 32'(puz_enable), 32'b010);
        check("run1_idx", 32'(cur_idx), 32'd1);
        check("run1_seg", seg_data, 32'h2222_2222);
        pulse_clear(3'b010);
        show3("ok1_seg", 32'hAAAA_AAAA);
        check("run2_en", 32'(puz_enable), 32'b100);
        pulse_clear(3'b100);
        show3("ok2_seg", 32'hAAAA_AAAA);
        check("done", 32'(phase_done), 32'd1);
        check("done_idx", 32'(cur_idx), 32'd2);
        check("done_en", 32'(puz_enable), 32'b000);
        check("done_timer", 32'(timer_data), 32'd5);

        // Restart, then lose by three wrong submissions.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("rs_done_clr", 32'(phase_done), 32'd0);
        check("rs_lives", 32'(lives), 32'd3);
        pulse_fail(3'b100);
        check("ign_en", 32'(puz_enable), 32'b001);
        check("ign_lives", 32'(lives), 32'd3);
        pulse_fail(3'b001);
        check("ng1_lives", 32'(lives), 32'd2);
        check("ng_led", 32'(led_out), 32'h00);
        show3("ng1_seg", 32'hEEEE_EEEE);
        check("ng1_back", 32'(puz_enable), 32'b001);
        pulse_fail(3'b001);
        check("ng2_lives", 32'(lives), 32'd1);
        show3("ng2_seg", 32'hEEEE_EEEE);
        check("ng2_idx", 32'(cur_idx), 32'd0);
        pulse_fail(3'b001);
        check("lost_fail", 32'(phase_fail), 32'd1);
        check("lost_lives", 32'(lives), 32'd0);
        check("lost_seg", seg_data, 32'hEEEE_EEEE);
        check("lost_timer", 32'(timer_data), 32'd4);

        // Run the clock down.
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("rs_fail_clr", 32'(phase_fail), 32'd0);
        check("rs_timer", 32'(timer_data), 32'd5);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k % 4 == 0 || k == 19)
                check("tmr", 32'(timer_data), 32'(5 - k / 4));
            if (k == 19)
                check("tmr_run", 32'(phase_fail), 32'd0);
        end
        check("tmo_fail", 32'(phase_fail), 32'd1);
        check("tmo_timer", 32'(timer_data), 32'd0);

        // Clear wins over fail in the same cycle.
        start = 1'b1;
        cyc();
        start = 1'b0;
        puz_clear = 3'b001;
        puz_fail  = 3'b001;
        cyc();
        puz_clear = '0;
        puz_fail  = '0;
        check("prio_seg", seg_data, 32'hAAAA_AAAA);
        check("prio_lives", 32'(lives), 32'd3);
        key_valid = 1'b1;
        #1;
        check("show_kv", 32'(puz_key_valid), 32'd0);
        key_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        check("prio_next", 32'(puz_enable), 32'b010);
        for (int k = 0; k < 7; k++) cyc();
        check("mid_timer", 32'(timer_data), 32'd3);
        check("mid_idx", 32'(cur_idx), 32'd1);

        // Mid-phase reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mr_en", 32'(puz_enable), 32'b000);
        check("mr_timer", 32'(timer_data), 32'd5);
        check("mr_lives", 32'(lives), 32'd3);
        check("mr_idx", 32'(cur_idx), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("mr_run_en", 32'(puz_enable), 32'b001);
        check("mr_run_idx", 32'(cur_idx), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
